// File: rtl/mmss_timer.sv
// rtl/mmss_timer.sv - mm:ss up/down timer with prescaler, preset load and 7-segment outputs
module mmss_timer #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int BLANK_LZ = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START_STOP,
    input  logic       CLR,
    input  logic       LOAD,
    input  logic [2:0] LD_M10,
    input  logic [3:0] LD_M1,
    input  logic [2:0] LD_S10,
    input  logic [3:0] LD_S1,
    input  logic       DOWN,
    output logic       RUN,
    output logic       DONE,
    output logic       TICK,
    output logic [2:0] M10,
    output logic [3:0] M1,
    output logic [2:0] S10,
    output logic [3:0] S1,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0] pre;
    logic          run;
    logic          done;
    logic          tick;
    logic [2:0]    m10, s10;
    logic [3:0]    m1, s1;

    logic [2:0]    nxt_m10, nxt_s10;
    logic [3:0]    nxt_m1, nxt_s1;
    logic          en;
    logic          time_zero;
    logic          nxt_zero;
    logic          start_blocked;

    assign en            = run && (pre == PRE_MAX);
    assign time_zero     = (m10 == 3'd0) && (m1 == 4'd0) && (s10 == 3'd0) && (s1 == 4'd0);
    assign nxt_zero      = (nxt_m10 == 3'd0) && (nxt_m1 == 4'd0) && (nxt_s10 == 3'd0) && (nxt_s1 == 4'd0);
    assign start_blocked = !run && DOWN && time_zero;

    // Digit-wise carry/borrow chain; counting down from 00:00 holds at zero
    always_comb begin
        nxt_m10 = m10;
        nxt_m1  = m1;
        nxt_s10 = s10;
        nxt_s1  = s1;
        if (!DOWN) begin
            if (s1 != 4'd9) begin
                nxt_s1 = s1 + 4'd1;
            end else begin
                nxt_s1 = 4'd0;
                if (s10 != 3'd5) begin
                    nxt_s10 = s10 + 3'd1;
                end else begin
                    nxt_s10 = 3'd0;
                    if (m1 != 4'd9) begin
                        nxt_m1 = m1 + 4'd1;
                    end else begin
                        nxt_m1  = 4'd0;
                        nxt_m10 = (m10 != 3'd5) ? m10 + 3'd1 : 3'd0;
                    end
                end
            end
        end else if (!time_zero) begin
            if (s1 != 4'd0) begin
                nxt_s1 = s1 - 4'd1;
            end else begin
                nxt_s1 = 4'd9;
                if (s10 != 3'd0) begin
                    nxt_s10 = s10 - 3'd1;
                end else begin
                    nxt_s10 = 3'd5;
                    if (m1 != 4'd0) begin
                        nxt_m1 = m1 - 4'd1;
                    end else begin
                        nxt_m1  = 4'd9;
                        nxt_m10 = (m10 != 3'd0) ? m10 - 3'd1 : 3'd5;
                    end
                end
            end
        end
    end

    // CLR > LOAD > START_STOP > tick; a start/stop cycle also freezes the prescaler
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pre  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
            tick <= 1'b0;
            m10  <= 3'd0;
            m1   <= 4'd0;
            s10  <= 3'd0;
            s1   <= 4'd0;
        end else if (CLR) begin
            pre  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
            tick <= 1'b0;
            m10  <= 3'd0;
            m1   <= 4'd0;
            s10  <= 3'd0;
            s1   <= 4'd0;
        end else if (LOAD) begin
            pre  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
            tick <= 1'b0;
            m10  <= (LD_M10 > 3'd5) ? 3'd5 : LD_M10;
            m1   <= (LD_M1  > 4'd9) ? 4'd9 : LD_M1;
            s10  <= (LD_S10 > 3'd5) ? 3'd5 : LD_S10;
            s1   <= (LD_S1  > 4'd9) ? 4'd9 : LD_S1;
        end else if (START_STOP) begin
            tick <= 1'b0;
            if (!start_blocked) begin
                run <= !run;
                if (!run) begin
                    done <= 1'b0;
                end
            end
        end else if (en) begin
            pre  <= '0;
            tick <= 1'b1;
            m10  <= nxt_m10;
            m1   <= nxt_m1;
            s10  <= nxt_s10;
            s1   <= nxt_s1;
            if (DOWN && nxt_zero) begin
                run  <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            tick <= 1'b0;
            if (run) begin
                pre <= pre + PW'(1);
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h58;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign RUN  = run;
    assign DONE = done;
    assign TICK = tick;
    assign M10  = m10;
    assign M1   = m1;
    assign S10  = s10;
    assign S1   = s1;

    assign HEX3 = ((BLANK_LZ != 0) && (m10 == 3'd0)) ? 7'h7F : seg7({1'b0, m10});
    assign HEX2 = seg7(m1);
    assign HEX1 = seg7({1'b0, s10});
    assign HEX0 = seg7(s1);

endmodule
